// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes, lane indices, code decode helpers and driver states shared with the intersection FSM.
package traffic_pkg;
  localparam logic [3:0] PH_NONE  = 4'd0;
  localparam logic [3:0] PH_NS1_G = 4'd1;
  localparam logic [3:0] PH_NS1_Y = 4'd2;
  localparam logic [3:0] PH_NS2_G = 4'd3;
  localparam logic [3:0] PH_NS2_Y = 4'd4;
  localparam logic [3:0] PH_EW1_G = 4'd5;
  localparam logic [3:0] PH_EW1_Y = 4'd6;
  localparam logic [3:0] PH_EW2_G = 4'd7;
  localparam logic [3:0] PH_EW2_Y = 4'd8;
  localparam logic [1:0] LANE_NS1 = 2'd0;
  localparam logic [1:0] LANE_NS2 = 2'd1;
  localparam logic [1:0] LANE_EW1 = 2'd2;
  localparam logic [1:0] LANE_EW2 = 2'd3;
  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_SHOW   = 2'd1,
    ST_FAULT  = 2'd2
  } drv_state_t;
  function automatic logic code_is_legal(input logic [3:0] c);
    return c >= PH_NS1_G && c <= PH_EW2_Y;
  endfunction
  function automatic logic [1:0] code_lane(input logic [3:0] c);
    logic [3:0] m;
    m = c - 4'd1;
    return m[2:1];
  endfunction
  function automatic logic code_is_yellow(input logic [3:0] c);
    return !c[0];
  endfunction
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction
endpackage

// File: rtl/tl_dwell_counter.sv
// tl_dwell_counter: saturating cycle counter; restart loads 1 (or 0 when not enabled), at_limit flags count >= LIMIT-EARLY.
module tl_dwell_counter #(
  parameter int LIMIT = 1,
  parameter bit EARLY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic at_limit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign at_limit = int'(cnt) >= LIMIT - int'(EARLY);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (restart) cnt <= en ? W'(1) : '0;
    else if (en && int'(cnt) < LIMIT) cnt <= cnt + W'(1);
endmodule

// File: rtl/traffic_light_driver.sv
// traffic_light_driver: decodes FSM phase codes into lamp drives with all-red clearance, minimum yellow and fault flash.
// Define TLD_FAULT_RECOVER_EN to leave FAULT after FAULT_LIMIT consecutive legal codes; otherwise FAULT holds until rst.
module traffic_light_driver import traffic_pkg::*; #(
  parameter int CLEAR_CYCLES = 2,
  parameter int MIN_YELLOW   = 3,
  parameter int FAULT_LIMIT  = 4,
  parameter int FLASH_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] light_signal,
  output logic [3:0] lamp_red,
  output logic [3:0] lamp_yellow,
  output logic [3:0] lamp_green,
  output logic [3:0] shown_code,
  output logic       fault
);
  drv_state_t st, st_n;
  logic [3:0] tgt, tgt_n, shown_n, mask_n, red_n, yel_n, grn_n;
  logic phase, phase_n;
  logic legal, go_fault, shown_yel;
  logic clr_rs, clr_en, clr_at;
  logic y_rs, y_en, y_at;
  logic fl_rs, fl_en, fl_at;
  logic ill_at;
  assign legal     = code_is_legal(light_signal);
  assign shown_yel = code_is_yellow(shown_code);
  assign go_fault  = !legal && ill_at && st != ST_FAULT;
  tl_dwell_counter #(.LIMIT(CLEAR_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .restart(clr_rs), .en(clr_en), .at_limit(clr_at)
  );
  tl_dwell_counter #(.LIMIT(MIN_YELLOW)) u_yellow (
    .clk(clk), .rst(rst), .restart(y_rs), .en(y_en), .at_limit(y_at)
  );
  tl_dwell_counter #(.LIMIT(FAULT_LIMIT), .EARLY(1'b1)) u_illegal (
    .clk(clk), .rst(rst), .restart(legal), .en(!legal), .at_limit(ill_at)
  );
  tl_dwell_counter #(.LIMIT(FLASH_PERIOD)) u_flash (
    .clk(clk), .rst(rst), .restart(fl_rs), .en(fl_en), .at_limit(fl_at)
  );
`ifdef TLD_FAULT_RECOVER_EN
  logic rec_at;
  tl_dwell_counter #(.LIMIT(FAULT_LIMIT), .EARLY(1'b1)) u_recover (
    .clk(clk), .rst(rst), .restart(!legal || st != ST_FAULT), .en(legal && st == ST_FAULT),
    .at_limit(rec_at)
  );
`endif
  always_comb begin
    st_n    = st;
    tgt_n   = tgt;
    shown_n = shown_code;
    phase_n = phase;
    clr_rs  = 1'b0;
    clr_en  = 1'b0;
    y_rs    = 1'b0;
    y_en    = 1'b0;
    fl_rs   = 1'b0;
    fl_en   = 1'b0;
    case (st)
      ST_ALLRED:
        if (tgt == PH_NONE) begin
          if (legal) begin
            tgt_n  = light_signal;
            clr_rs = 1'b1;
            clr_en = 1'b1;
          end
        end else if (clr_at) begin
          st_n    = ST_SHOW;
          shown_n = legal ? light_signal : tgt;
          tgt_n   = PH_NONE;
          y_rs    = 1'b1;
          y_en    = 1'b1;
        end else begin
          clr_en = 1'b1;
          tgt_n  = legal ? light_signal : tgt;
        end
      ST_SHOW: begin
        // Yellow dwell keeps counting while held so a deferred change fires once MIN_YELLOW is met.
        y_en = shown_yel;
        if (legal && light_signal != shown_code && (!shown_yel || y_at)) begin
          if (!shown_yel && light_signal == shown_code + 4'd1) begin
            shown_n = light_signal;
            y_rs    = 1'b1;
            y_en    = 1'b1;
          end else begin
            st_n    = ST_ALLRED;
            shown_n = PH_NONE;
            tgt_n   = light_signal;
            clr_rs  = 1'b1;
            clr_en  = 1'b1;
          end
        end
      end
      default: begin
        fl_en = 1'b1;
        if (fl_at) begin
          phase_n = !phase;
          fl_rs   = 1'b1;
        end
`ifdef TLD_FAULT_RECOVER_EN
        if (legal && rec_at) begin
          st_n  = ST_ALLRED;
          tgt_n = PH_NONE;
        end
`endif
      end
    endcase
    if (go_fault) begin
      st_n    = ST_FAULT;
      shown_n = PH_NONE;
      tgt_n   = PH_NONE;
      phase_n = 1'b1;
      fl_rs   = 1'b1;
      fl_en   = 1'b1;
    end
  end
  assign mask_n = lane_mask(code_lane(shown_n));
  assign red_n  = st_n == ST_FAULT ? {4{phase_n}} : shown_n == PH_NONE ? 4'hF : ~mask_n;
  assign yel_n  = shown_n != PH_NONE && code_is_yellow(shown_n) ? mask_n : 4'h0;
  assign grn_n  = shown_n != PH_NONE && !code_is_yellow(shown_n) ? mask_n : 4'h0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st          <= ST_ALLRED;
      tgt         <= PH_NONE;
      shown_code  <= PH_NONE;
      phase       <= 1'b1;
      lamp_red    <= 4'hF;
      lamp_yellow <= 4'h0;
      lamp_green  <= 4'h0;
      fault       <= 1'b0;
    end else begin
      st          <= st_n;
      tgt         <= tgt_n;
      shown_code  <= shown_n;
      phase       <= phase_n;
      lamp_red    <= red_n;
      lamp_yellow <= yel_n;
      lamp_green  <= grn_n;
      fault       <= st_n == ST_FAULT;
    end
endmodule

// File: tb/tb_traffic_light_driver.sv
// tb_traffic_light_driver: directed and random phase-code stimulus checked each cycle against a behavioural model.
module tb_traffic_light_driver;
  localparam int CLR = 2;
  localparam int MY  = 3;
  localparam int FL  = 4;
  localparam int FP  = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] light_signal = 4'd1;
  logic [3:0] lamp_red, lamp_yellow, lamp_green, shown_code;
  logic fault;
  int vectors = 0;
  int miscompares = 0;
  int m_mode, m_tgt, m_shown, m_left, m_yage, m_ill, m_good, m_fage;
  traffic_light_driver #(
    .CLEAR_CYCLES(CLR), .MIN_YELLOW(MY), .FAULT_LIMIT(FL), .FLASH_PERIOD(FP)
  ) dut (
    .clk(clk), .rst(rst), .light_signal(light_signal), .lamp_red(lamp_red),
    .lamp_yellow(lamp_yellow), .lamp_green(lamp_green), .shown_code(shown_code), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: mode 0 all-red, 1 showing, 2 fault; m_left = clearance cycles still owed after this one.
  task automatic m_step(input int c);
    bit legal;
    bit yel;
    legal = c >= 1 && c <= 8;
    if (m_mode != 2 && !legal && m_ill + 1 >= FL) begin
      m_mode = 2; m_shown = 0; m_tgt = 0; m_fage = 0; m_good = 0;
    end else if (m_mode == 0) begin
      if (m_tgt == 0) begin
        if (legal) begin m_tgt = c; m_left = CLR - 1; end
      end else if (m_left == 0) begin
        m_mode = 1; m_shown = legal ? c : m_tgt; m_tgt = 0; m_yage = 1;
      end else begin
        m_left--;
        if (legal) m_tgt = c;
      end
    end else if (m_mode == 1) begin
      yel = m_shown % 2 == 0;
      if (legal && c != m_shown && (!yel || m_yage >= MY)) begin
        if (!yel && c == m_shown + 1) begin m_shown = c; m_yage = 1; end
        else begin m_mode = 0; m_shown = 0; m_tgt = c; m_left = CLR - 1; end
      end else m_yage++;
    end else begin
      m_fage++;
      m_good = legal ? m_good + 1 : 0;
`ifdef TLD_FAULT_RECOVER_EN
      if (m_good >= FL) begin m_mode = 0; m_tgt = 0; end
`endif
    end
    m_ill = legal ? 0 : m_ill + 1;
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_mode = 0; m_tgt = 0; m_shown = 0; m_left = 0; m_yage = 0; m_ill = 0; m_good = 0; m_fage = 0;
    end else m_step(int'(light_signal));
  function automatic logic [3:0] e_mask();
    return m_shown == 0 ? 4'h0 : 4'(1 << ((m_shown - 1) / 2));
  endfunction
  function automatic logic [3:0] e_red();
    if (m_mode == 2) return ((m_fage / FP) % 2 == 0) ? 4'hF : 4'h0;
    return m_shown == 0 ? 4'hF : ~e_mask();
  endfunction
  function automatic logic [3:0] e_yel();
    return (m_shown != 0 && m_shown % 2 == 0) ? e_mask() : 4'h0;
  endfunction
  function automatic logic [3:0] e_grn();
    return (m_shown % 2 == 1) ? e_mask() : 4'h0;
  endfunction
  always @(negedge clk)
    if (!rst) begin
      chk("lamp_red", lamp_red, e_red());
      chk("lamp_yellow", lamp_yellow, e_yel());
      chk("lamp_green", lamp_green, e_grn());
      chk("shown_code", shown_code, m_shown);
      chk("fault", fault, m_mode == 2);
      if (!fault) begin
        chk("one_lamp_per_lane", ((lamp_red ^ lamp_yellow ^ lamp_green) &
            ~(lamp_red & lamp_yellow) & ~(lamp_red & lamp_green) & ~(lamp_yellow & lamp_green)), 4'hF);
        chk("single_nonred_lane", $countones(lamp_yellow | lamp_green) <= 1, 1);
      end
    end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int r, c, hold;
    cycles(2);
    chk("reset_red", lamp_red, 4'hF);
    chk("reset_fault", fault, 0);
    rst = 1'b0;
    cycles(1);
    chk("clear1_red", lamp_red, 4'hF);
    cycles(1);
    chk("clear2_red", lamp_red, 4'hF);
    cycles(1);
    chk("first_green", lamp_green, 4'b0001);
    chk("first_red", lamp_red, 4'b1110);
    chk("first_shown", shown_code, 4'd1);
    light_signal = 4'd2;
    cycles(1);
    chk("direct_yellow", lamp_yellow, 4'b0001);
    chk("direct_yellow_red", lamp_red, 4'b1110);
    light_signal = 4'd3;
    cycles(2);
    chk("yellow_dwell3", lamp_yellow, 4'b0001);
    cycles(1);
    chk("after_yellow_allred", lamp_red, 4'hF);
    cycles(2);
    chk("ns2_green", lamp_green, 4'b0010);
    light_signal = 4'd7;
    cycles(1);
    light_signal = 4'd5;
    cycles(1);
    chk("retarget_allred", lamp_red, 4'hF);
    cycles(1);
    chk("retarget_green", lamp_green, 4'b0100);
    light_signal = 4'd0;
    cycles(3);
    chk("illegal3_fault", fault, 0);
    chk("illegal3_green", lamp_green, 4'b0100);
    light_signal = 4'd5;
    cycles(1);
    light_signal = 4'd12;
    cycles(3);
    chk("illegal3b_fault", fault, 0);
    cycles(1);
    chk("fault_entry", fault, 1);
    chk("fault_red_lit", lamp_red, 4'hF);
    chk("fault_green", lamp_green, 4'h0);
    cycles(8);
    chk("fault_red_dark", lamp_red, 4'h0);
    cycles(8);
    chk("fault_red_relit", lamp_red, 4'hF);
    light_signal = 4'd1;
    cycles(4);
`ifdef TLD_FAULT_RECOVER_EN
    chk("recover_fault", fault, 0);
    cycles(3);
    chk("recover_green", lamp_green, 4'b0001);
`else
    chk("sticky_fault", fault, 1);
    chk("sticky_green", lamp_green, 4'h0);
`endif
    #1 rst = 1'b1;
    cycles(1);
    #1 rst = 1'b0;
    light_signal = 4'd12;
    cycles(13);
    chk("midfault_dark", lamp_red, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_red", lamp_red, 4'hF);
    chk("async_rst_fault", fault, 0);
    chk("async_rst_shown", shown_code, 4'd0);
    cycles(1);
    #1 rst = 1'b0;
    light_signal = 4'd3;
    cycles(1);
    #2 rst = 1'b1;
    #1;
    chk("midclear_rst_red", lamp_red, 4'hF);
    cycles(1);
    #1 rst = 1'b0;
    for (int s = 0; s < 700; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b1;
        cycles(1);
        #1 rst = 1'b0;
      end
      r = int'($urandom_range(0, 99));
      if (r < 8) c = 0;
      else if (r < 15) c = int'($urandom_range(9, 15));
      else if (r < 50 && m_shown % 2 == 1) c = m_shown + 1;
      else c = int'($urandom_range(1, 8));
      hold = int'($urandom_range(1, 5));
      light_signal = 4'(c);
      cycles(hold);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
